// File: rtl/rpn_stack_ctrl.sv
// rtl/rpn_stack_ctrl.sv - RPN calculator stack sequencer: SP, top-of-stack, RAM and ALU operand control
module rpn_stack_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] top,
    output logic [ADDR_W-1:0] depth,
    output logic [1:0]        err
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [3:0] OP_PUSH  = 4'd0;
    localparam logic [3:0] OP_POP   = 4'd1;
    localparam logic [3:0] OP_DUP   = 4'd2;
    localparam logic [3:0] OP_CLEAR = 4'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_POP, S_LDTOP, S_RDA, S_CAPA, S_EXEC
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] sp, sp_n;
    logic [DATA_W-1:0] top_r, top_n;
    logic [DATA_W-1:0] alu_a_r, alu_a_n;
    logic [2:0]        alu_op_r, alu_op_n;
    logic [1:0]        err_r, err_n;
    logic [DATA_W-1:0] wdata_r, wdata_n;
    logic              accept;

    assign cmd_ready = (state == S_IDLE) && !RESET;
    assign accept    = cmd_valid && (state == S_IDLE);
    assign alu_a     = alu_a_r;
    assign alu_b     = top_r;
    assign alu_op    = alu_op_r;
    assign top       = top_r;
    assign depth     = sp;
    assign err       = err_r;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state    <= S_IDLE;
            sp       <= '0;
            top_r    <= '0;
            alu_a_r  <= '0;
            alu_op_r <= '0;
            err_r    <= '0;
            wdata_r  <= '0;
        end else begin
            state    <= state_n;
            sp       <= sp_n;
            top_r    <= top_n;
            alu_a_r  <= alu_a_n;
            alu_op_r <= alu_op_n;
            err_r    <= err_n;
            wdata_r  <= wdata_n;
        end
    end

    always_comb begin
        state_n   = state;
        sp_n      = sp;
        top_n     = top_r;
        alu_a_n   = alu_a_r;
        alu_op_n  = alu_op_r;
        err_n     = err_r;
        wdata_n   = wdata_r;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    err_n    = 2'b00;
                    alu_op_n = cmd_op[2:0];
                    wdata_n  = (cmd_op == OP_DUP) ? top_r : cmd_data;
                    if (cmd_op[3]) begin
                        if (sp < ADDR_W'(2)) err_n = 2'b10;
                        else                 state_n = S_RDA;
                    end else begin
                        case (cmd_op)
                            OP_PUSH: begin
                                if (sp == DEPTH_A) err_n = 2'b01;
                                else               state_n = S_WR;
                            end
                            OP_POP: begin
                                if (sp == '0) err_n = 2'b10;
                                else          state_n = S_POP;
                            end
                            OP_DUP: begin
                                if (sp == DEPTH_A)  err_n = 2'b01;
                                else if (sp == '0)  err_n = 2'b10;
                                else                state_n = S_WR;
                            end
                            OP_CLEAR: begin
                                sp_n  = '0;
                                top_n = '0;
                            end
                            default: err_n = 2'b11;
                        endcase
                    end
                end
            end
            S_WR: begin
                mem_addr  = sp;
                mem_we    = 1'b1;
                mem_wdata = wdata_r;
                sp_n      = sp + ADDR_W'(1);
                top_n     = wdata_r;
                state_n   = S_IDLE;
            end
            S_POP: begin
                // The new top lives one below the popped slot; read it now, capture it next cycle.
                mem_addr = sp - ADDR_W'(2);
                sp_n     = sp - ADDR_W'(1);
                if (sp == ADDR_W'(1)) begin
                    top_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    state_n = S_LDTOP;
                end
            end
            S_LDTOP: begin
                mem_addr = sp - ADDR_W'(1);
                top_n    = mem_rdata;
                state_n  = S_IDLE;
            end
            S_RDA: begin
                mem_addr = sp - ADDR_W'(2);
                state_n  = S_CAPA;
            end
            S_CAPA: begin
                mem_addr = sp - ADDR_W'(2);
                alu_a_n  = mem_rdata;
                state_n  = S_EXEC;
            end
            S_EXEC: begin
                // Result replaces the deeper operand's slot and becomes the new top.
                mem_addr  = sp - ADDR_W'(2);
                mem_we    = 1'b1;
                mem_wdata = alu_result;
                top_n     = alu_result;
                sp_n      = sp - ADDR_W'(1);
                state_n   = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// tb/tb_rpn_stack_ctrl.sv - self-checking bench for rpn_stack_ctrl with RAM and ALU models
module tb_rpn_stack_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       RESET;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
    logic [7:0] top;
    logic [7:0] depth;
    logic [1:0] err;

    logic [7:0] ram [0:255];
    int tests = 0;
    int fails = 0;
    int we_cnt = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    rpn_stack_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(16)) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .top(top), .depth(depth), .err(err)
    );

    always @(posedge CLOCK_50) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        mem_rdata <= ram[mem_addr];
    end

    always_comb begin
        case (alu_op)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            3'd2:    alu_result = alu_a & alu_b;
            3'd3:    alu_result = alu_a | alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    typedef struct {
        logic [3:0] op;
        logic [7:0] data;
        int e_err;
        int e_depth;
        int e_top;
        int e_busy;
        int e_wr;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Issue one command from a negedge; returns cycles spent busy and writes seen.
    task automatic do_cmd(input logic [3:0] op, input logic [7:0] data, output int busy, output int wr);
        int n;
        int w0;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("ready_before_cmd", cmd_ready, 1);
        w0 = we_cnt;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(negedge CLOCK_50);
        cmd_valid = 1'b0;
        n = 0;
        while (!cmd_ready && n < 50) begin
            n++;
            @(negedge CLOCK_50);
        end
        busy = n;
        wr   = we_cnt - w0;
    endtask

    initial begin
        int busy, wr;
        string nm;
        vecs[0]  = '{4'd0, 8'h05, 0, 1, 8'h05, 1, 1};
        vecs[1]  = '{4'd0, 8'h03, 0, 2, 8'h03, 1, 1};
        vecs[2]  = '{4'd9, 8'h00, 0, 1, 8'h02, 3, 1};
        vecs[3]  = '{4'd3, 8'h00, 0, 0, 8'h00, 0, 0};
        vecs[4]  = '{4'd0, 8'h07, 0, 1, 8'h07, 1, 1};
        vecs[5]  = '{4'd0, 8'h09, 0, 2, 8'h09, 1, 1};
        vecs[6]  = '{4'd1, 8'h00, 0, 1, 8'h07, 2, 0};
        vecs[7]  = '{4'd1, 8'h00, 0, 0, 8'h00, 1, 0};
        vecs[8]  = '{4'd1, 8'h00, 2, 0, 8'h00, 0, 0};
        vecs[9]  = '{4'd0, 8'h01, 0, 1, 8'h01, 1, 1};
        vecs[10] = '{4'd8, 8'h00, 2, 1, 8'h01, 0, 0};
        vecs[11] = '{4'd5, 8'h00, 3, 1, 8'h01, 0, 0};
        vecs[12] = '{4'd2, 8'h00, 0, 2, 8'h01, 1, 1};
        vecs[13] = '{4'd8, 8'h00, 0, 1, 8'h02, 3, 1};
        vecs[14] = '{4'd3, 8'h00, 0, 0, 8'h00, 0, 0};
        vecs[15] = '{4'd0, 8'hF0, 0, 1, 8'hF0, 1, 1};
        vecs[16] = '{4'd0, 8'h20, 0, 2, 8'h20, 1, 1};
        vecs[17] = '{4'd8, 8'h00, 0, 1, 8'h10, 3, 1};
        vecs[18] = '{4'd3, 8'h00, 0, 0, 8'h00, 0, 0};

        RESET = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_data = '0;
        repeat (2) @(negedge CLOCK_50);
        check("rst_depth", depth, 0);
        check("rst_top", top, 0);
        check("rst_err", err, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_alu_a", alu_a, 0);
        RESET = 1'b0;
        @(negedge CLOCK_50);
        check("rst_ready", cmd_ready, 1);

        for (int i = 0; i < 19; i++) begin
            do_cmd(vecs[i].op, vecs[i].data, busy, wr);
            nm = $sformatf("v%0d", i);
            check({nm, "_err"}, err, vecs[i].e_err);
            check({nm, "_depth"}, depth, vecs[i].e_depth);
            check({nm, "_top"}, top, vecs[i].e_top);
            check({nm, "_busy"}, busy, vecs[i].e_busy);
            check({nm, "_writes"}, wr, vecs[i].e_wr);
            if (i == 2 || i == 17) check({nm, "_ram0"}, ram[0], (i == 2) ? 8'h02 : 8'h10);
        end

        // CLEAR takes effect on its accept edge.
        do_cmd(4'd0, 8'h33, busy, wr);
        cmd_valid = 1'b1;
        cmd_op = 4'd3;
        @(posedge CLOCK_50);
        #1;
        cmd_valid = 1'b0;
        check("clear_depth_at_edge", depth, 0);
        check("clear_top_at_edge", top, 0);
        @(negedge CLOCK_50);

        // Fill to capacity, then overflow on PUSH and DUP.
        for (int i = 0; i < 16; i++) do_cmd(4'd0, 8'(i), busy, wr);
        check("full_depth", depth, 16);
        check("full_top", top, 15);
        do_cmd(4'd0, 8'hAA, busy, wr);
        check("ovf_push_err", err, 1);
        check("ovf_push_writes", wr, 0);
        check("ovf_push_top", top, 15);
        check("ovf_push_depth", depth, 16);
        do_cmd(4'd2, 8'h00, busy, wr);
        check("ovf_dup_err", err, 1);
        check("ovf_dup_depth", depth, 16);

        // Asynchronous reset while the ADD sits in S_CAPA.
        do_cmd(4'd3, 8'h00, busy, wr);
        do_cmd(4'd0, 8'h11, busy, wr);
        do_cmd(4'd0, 8'h22, busy, wr);
        cmd_valid = 1'b1;
        cmd_op = 4'd8;
        @(negedge CLOCK_50);
        cmd_valid = 1'b0;
        @(negedge CLOCK_50);
        check("pre_rst_ready_low", cmd_ready, 0);
        RESET = 1'b1;
        #1;
        check("arst_depth", depth, 0);
        check("arst_top", top, 0);
        check("arst_err", err, 0);
        check("arst_we", mem_we, 0);
        @(negedge CLOCK_50);
        RESET = 1'b0;
        #1;
        check("arst_ready", cmd_ready, 1);
        @(negedge CLOCK_50);
        do_cmd(4'd0, 8'h04, busy, wr);
        check("post_rst_depth", depth, 1);
        check("post_rst_top", top, 4);
        check("post_rst_writes", wr, 1);

        // cmd_valid held through a busy PUSH: second command taken once, when ready returns.
        begin
            int w0;
            int n;
            w0 = we_cnt;
            cmd_valid = 1'b1;
            cmd_op = 4'd0;
            cmd_data = 8'h55;
            @(negedge CLOCK_50);
            cmd_data = 8'h66;
            check("held_busy_ready", cmd_ready, 0);
            check("held_busy_depth", depth, 1);
            @(negedge CLOCK_50);
            check("held_ready_back", cmd_ready, 1);
            check("held_mid_depth", depth, 2);
            check("held_mid_top", top, 8'h55);
            @(negedge CLOCK_50);
            cmd_valid = 1'b0;
            n = 0;
            while (!cmd_ready && n < 50) begin
                n++;
                @(negedge CLOCK_50);
            end
            check("held_busy2", n, 1);
            check("held_depth", depth, 3);
            check("held_top", top, 8'h66);
            check("held_writes", we_cnt - w0, 2);
            repeat (2) @(negedge CLOCK_50);
            check("held_no_extra", depth, 3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
